// File: rtl/vga_scanout.sv
// VGA 640x480@60 scanout engine: pixel-enable timing, 2x2-replicated frame-buffer
// address generation and RGB565-to-444 conversion with aligned sync outputs.
module vga_scanout #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int FB_WIDTH  = 320,
  parameter int CLK_DIV   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [16:0] fb_addr,
  input  logic [15:0] fb_rdata,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic        active
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_SS   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SE   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SS   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SE   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d, v_q, v_d;
  logic [16:0]      addr_q, addr_d;
  logic [3:0]       r_q, g_q, b_q;
  logic             hs_q, vs_q, fs_q, act_q;
  logic             tick, visible;

  // Row base address; the default 320-wide buffer uses a shift-add instead of a multiplier.
  function automatic logic [16:0] row_base(input logic [8:0] y);
    logic [16:0] yy;
    yy = {8'b0, y};
    if (FB_WIDTH == 320) return (yy << 8) + (yy << 6);
    else                 return 17'(32'(y) * FB_WIDTH);
  endfunction

  function automatic logic [11:0] rgb565_to_444(input logic [15:0] px);
    return {px[15:12], px[10:7], px[4:1]};
  endfunction

  assign tick    = (div_q == DIV_LAST);
  assign visible = (h_q < H_VIS) && (v_q < V_VIS);

  always_comb begin
    div_d  = tick ? '0 : div_q + 1'b1;
    h_d    = h_q;
    v_d    = v_q;
    addr_d = addr_q;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
    // Fetch at the start of the pixel period so the RAM answer settles before the tick.
    if (div_q == '0 && visible)
      addr_d = row_base(v_q[9:1]) + {8'b0, h_q[9:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      h_q    <= '0;
      v_q    <= '0;
      addr_q <= '0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      fs_q   <= 1'b0;
      act_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      h_q    <= h_d;
      v_q    <= v_d;
      addr_q <= addr_d;
      fs_q   <= tick && (h_q == '0) && (v_q == '0);
      if (tick) begin
        {r_q, g_q, b_q} <= visible ? rgb565_to_444(fb_rdata) : 12'h000;
        hs_q  <= !((h_q >= H_SS) && (h_q <= H_SE));
        vs_q  <= !((v_q >= V_SS) && (v_q <= V_SE));
        act_q <= visible;
      end
    end
  end

  assign fb_addr     = addr_q;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign frame_start = fs_q;
  assign active      = act_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench: a default-size instance for line timing, addressing and colour,
// and a shrunken-timing instance for whole-frame timing and mid-line reset.
module tb_vga_scanout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic        rst_b, rst_s;
  logic [15:0] word_b, word_s, rd_b, rd_s;
  logic [16:0] addr_b, addr_s;
  logic [3:0]  r_b, g_b, b_b, r_s, g_s, b_s;
  logic        hs_b, vs_b, fs_b, act_b, hs_s, vs_s, fs_s, act_s;

  // Synchronous RAM stand-ins: a constant word, one clock of read latency.
  always_ff @(posedge clk) rd_b <= word_b;
  always_ff @(posedge clk) rd_s <= word_s;

  vga_scanout u_big (
    .clk(clk), .rst(rst_b), .fb_addr(addr_b), .fb_rdata(rd_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .hsync(hs_b), .vsync(vs_b),
    .frame_start(fs_b), .active(act_b)
  );

  // 24 px/line (16+2+4+2), 12 lines/frame (8+1+2+1): 96 clk lines, 1152 clk frames.
  vga_scanout #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_VISIBLE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .FB_WIDTH(8), .CLK_DIV(4)
  ) u_sml (
    .clk(clk), .rst(rst_s), .fb_addr(addr_s), .fb_rdata(rd_s),
    .vga_r(r_s), .vga_g(g_s), .vga_b(b_s), .hsync(hs_s), .vsync(vs_s),
    .frame_start(fs_s), .active(act_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_b(input string tag);
    chk({tag, "_addr"}, addr_b, 0);
    chk({tag, "_rgb"}, {r_b, g_b, b_b}, 0);
    chk({tag, "_sync"}, {hs_b, vs_b}, 2'b11);
    chk({tag, "_fs_act"}, {fs_b, act_b}, 2'b00);
  endtask

  task automatic chk_reset_s(input string tag);
    chk({tag, "_addr"}, addr_s, 0);
    chk({tag, "_rgb"}, {r_s, g_s, b_s}, 0);
    chk({tag, "_sync"}, {hs_s, vs_s}, 2'b11);
    chk({tag, "_fs_act"}, {fs_s, act_s}, 2'b00);
  endtask

  // Edge c is the c-th rising edge after reset release; outputs sampled 1 time unit later.
  task automatic run_big();
    int   hs_f1 = -1, hs_r1 = -1, hs_f2 = -1, fs_n = 0, vs_low = 0;
    logic hs_p = 1'b1;
    for (int c = 1; c <= 6410; c++) begin
      if (c == 4000) word_b = 16'h07E0;
      @(posedge clk); #1;
      if (!hs_b && hs_p) begin
        if (hs_f1 < 0) hs_f1 = c;
        else if (hs_f2 < 0) hs_f2 = c;
      end
      if (hs_b && !hs_p && hs_r1 < 0) hs_r1 = c;
      hs_p = hs_b;
      if (fs_b) fs_n++;
      if (!vs_b) vs_low++;
      case (c)
        1:    chk("big_addr_0_0", addr_b, 0);
        3:    chk("big_pre_tick", {hs_b, act_b, r_b, g_b, b_b}, {2'b10, 12'h000});
        4:    chk("big_pix00", {fs_b, act_b, r_b, g_b, b_b}, {2'b11, 12'hF0F});
        5:    chk("big_fs_end_addr", {fs_b, 15'b0, addr_b}, 0);
        9:    chk("big_addr_2_0", addr_b, 1);
        2700: chk("big_blank_rgb", {act_b, r_b, g_b, b_b}, 0);
        2801: chk("big_addr_hold", addr_b, 319);
        3199: chk("big_addr_hold2", addr_b, 319);
        3205: chk("big_addr_1_1", addr_b, 0);
        4100: chk("big_rgb_07e0", {act_b, r_b, g_b, b_b}, {1'b1, 12'h0F0});
        6401: chk("big_addr_0_2", addr_b, 320);
        default: ;
      endcase
    end
    chk("big_hs_fall", hs_f1, 2628);
    chk("big_hs_rise", hs_r1, 3012);
    chk("big_line_period", hs_f2 - hs_f1, 3200);
    chk("big_fs_count", fs_n, 1);
    chk("big_vs_low", vs_low, 0);
  endtask

  task automatic run_small(input int n, input string tag);
    int   fs1 = -1, fs2 = -1, fs_n = 0, hs_f1 = -1, hs_r1 = -1, vs_f1 = -1, vs_r1 = -1;
    logic hs_p = 1'b1, vs_p = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      if (!hs_s && hs_p && hs_f1 < 0) hs_f1 = c;
      if (hs_s && !hs_p && hs_f1 > 0 && hs_r1 < 0) hs_r1 = c;
      if (!vs_s && vs_p && vs_f1 < 0) vs_f1 = c;
      if (vs_s && !vs_p && vs_f1 > 0 && vs_r1 < 0) vs_r1 = c;
      hs_p = hs_s;
      vs_p = vs_s;
      if (fs_s) begin
        fs_n++;
        if (fs1 < 0) fs1 = c;
        else if (fs2 < 0) fs2 = c;
      end
      case (c)
        3:    chk({tag, "_pre_tick"}, {hs_s, vs_s, act_s, r_s, g_s, b_s}, {3'b110, 12'h000});
        4:    chk({tag, "_pix00"}, {act_s, r_s, g_s, b_s}, {1'b1, 12'hF0F});
        733:  chk({tag, "_addr_last"}, addr_s, 31);
        1000: chk({tag, "_addr_hold"}, addr_s, 31);
        1153: chk({tag, "_addr_wrap"}, addr_s, 0);
        default: ;
      endcase
    end
    chk({tag, "_fs_first"}, fs1, 4);
    chk({tag, "_frame_period"}, fs2 - fs1, 1152);
    chk({tag, "_fs_count"}, fs_n, 2);
    chk({tag, "_hs_fall"}, hs_f1, 76);
    chk({tag, "_hs_width"}, hs_r1 - hs_f1, 16);
    chk({tag, "_vs_fall"}, vs_f1, 868);
    chk({tag, "_vs_width"}, vs_r1 - vs_f1, 192);
  endtask

  initial begin
    rst_b  = 1'b1;
    rst_s  = 1'b1;
    word_b = 16'hF81F;
    word_s = 16'hF81F;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_b("big_reset");
    chk_reset_s("sml_reset");

    rst_b = 1'b0;
    run_big();

    rst_s = 1'b0;
    run_small(1578, "sml_run1");
    chk("sml_pre_rst_active", {act_s, r_s, g_s, b_s}, {1'b1, 12'hF0F});
    rst_s = 1'b1;
    @(posedge clk); #1;
    chk_reset_s("sml_midline_rst");
    rst_s = 1'b0;
    run_small(1200, "sml_run2");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
